// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants, FSM state encoding and channel-search helper
// Contents:
//   ADC_NUM_CH          analog channels on the ADC0808
//   ADC_CLK_DIV_DEFAULT clk cycles per ADC clock (100 MHz -> 50 kHz)
//   state_t / ST_*      scanner FSM state enumeration
//   next_ch()           next set mask bit above ptr, wrapping 7 -> 0
package adc_pkg;

  localparam int ADC_NUM_CH          = 8;
  localparam int ADC_CLK_DIV_DEFAULT = 2000;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_LATCH   = 3'd2;
  localparam state_t ST_START   = 3'd3;
  localparam state_t ST_WAIT_LO = 3'd4;
  localparam state_t ST_WAIT_HI = 3'd5;
  localparam state_t ST_READ    = 3'd6;
  localparam state_t ST_CAPTURE = 3'd7;

  // Walks downward so the nearest set bit above ptr wins; offset 8 wraps
  // back to ptr itself, which is what a single-bit mask must return.
  function automatic logic [2:0] next_ch(input logic [2:0] ptr, input logic [7:0] mask);
    logic [2:0] r;
    logic [2:0] idx;
    r = ptr;
    for (int i = ADC_NUM_CH; i >= 1; i--) begin
      idx = ptr + 3'(i);
      if (mask[idx]) r = idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// rtl/adc_clk_div.sv - ADC clock divider with one-clk tick on each adc_clk rise
// Ports:
//   clk, reset_n  system clock, async active-low reset
//   adc_clk       clk / CLK_DIV, 50% duty
//   adc_tick      one-clk pulse coincident with each adc_clk rising edge
module adc_clk_div
  import adc_pkg::*;
#(
  parameter int CLK_DIV = ADC_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  output logic adc_clk,
  output logic adc_tick
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;
  logic          half_done;

  assign half_done = (cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      adc_clk  <= 1'b0;
      adc_tick <= 1'b0;
    end else begin
      adc_tick <= 1'b0;
      if (half_done) begin
        cnt      <= '0;
        adc_clk  <= ~adc_clk;
        adc_tick <= ~adc_clk;  // only the low->high toggle produces a tick
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/adc0808_scanner.sv
// rtl/adc0808_scanner.sv - ADC0808 channel scanner with per-channel averaging
// Ports:
//   clk, reset_n           system clock, async active-low reset
//   enable, ch_mask        scan enable and channel selection
//   adc_data, adc_eoc      ADC0808 data bus and end-of-conversion (async)
//   adc_clk                ADC0808 clock
//   adc_ale/start/oe/addr  ADC0808 controls and channel address
//   sample_data/ch/valid   averaged result, its channel, one-clk strobe
//   timeout_err            sticky EOC timeout flag
module adc0808_scanner
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = ADC_CLK_DIV_DEFAULT,
  parameter int AVG_LOG2    = 0,
  parameter int EOC_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] ch_mask,
  input  logic [7:0] adc_data,
  input  logic       adc_eoc,
  output logic       adc_clk,
  output logic       adc_ale,
  output logic       adc_start,
  output logic       adc_oe,
  output logic [2:0] adc_addr,
  output logic [7:0] sample_data,
  output logic [2:0] sample_ch,
  output logic       sample_valid,
  output logic       timeout_err
);

  localparam int             ACC_W      = 8 + AVG_LOG2;
  localparam int             TW         = (EOC_TIMEOUT > 1) ? $clog2(EOC_TIMEOUT + 1) : 1;
  localparam logic [3:0]     LAST_CONV  = 4'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(EOC_TIMEOUT - 1);

  logic             adc_tick;
  logic             eoc_meta;
  logic             eoc_sync;
  state_t           state;
  logic [2:0]       scan_ptr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [3:0]       conv_cnt;
  logic [TW-1:0]    timer;
  logic             timer_expired;

  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .adc_clk  (adc_clk),
    .adc_tick (adc_tick)
  );

  // Controls decode straight from state so reset clears them asynchronously.
  assign adc_ale       = (state == ST_LATCH);
  assign adc_start     = (state == ST_START);
  assign adc_oe        = (state == ST_READ) || (state == ST_CAPTURE);
  assign acc_sum       = acc + ACC_W'(adc_data);
  assign timer_expired = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eoc_meta     <= 1'b0;
      eoc_sync     <= 1'b0;
      state        <= ST_IDLE;
      scan_ptr     <= 3'd7;
      adc_addr     <= 3'd0;
      acc          <= '0;
      conv_cnt     <= 4'd0;
      timer        <= '0;
      sample_data  <= 8'd0;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      eoc_meta     <= adc_eoc;
      eoc_sync     <= eoc_meta;
      sample_valid <= 1'b0;
      if (state == ST_CAPTURE) begin
        // CAPTURE runs one clk after READ's tick, independent of adc_tick.
        if (conv_cnt == LAST_CONV) begin
          sample_data  <= acc_sum[ACC_W-1 -: 8];
          sample_ch    <= scan_ptr;
          sample_valid <= 1'b1;
          acc          <= '0;
          conv_cnt     <= 4'd0;
          state        <= ST_IDLE;
        end else begin
          acc      <= acc_sum;
          conv_cnt <= conv_cnt + 4'd1;
          state    <= ST_LATCH;
        end
      end else if (adc_tick) begin
        case (state)
          ST_IDLE: begin
            if (enable && (ch_mask != 8'd0)) begin
              scan_ptr <= next_ch(scan_ptr, ch_mask);
              adc_addr <= next_ch(scan_ptr, ch_mask);
              state    <= ST_SELECT;
            end
          end
          ST_SELECT: state <= ST_LATCH;
          ST_LATCH:  state <= ST_START;
          ST_START: begin
            timer <= '0;
            state <= ST_WAIT_LO;
          end
          ST_WAIT_LO, ST_WAIT_HI: begin
            if (eoc_sync == (state == ST_WAIT_HI)) begin
              timer <= '0;
              state <= (state == ST_WAIT_LO) ? ST_WAIT_HI : ST_READ;
            end else if (timer_expired) begin
              timeout_err <= 1'b1;
              acc         <= '0;
              conv_cnt    <= 4'd0;
              state       <= ST_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_READ: state <= ST_CAPTURE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/adc0808_scanner.md
ADC0808_SCANNER -- requirements
Module: adc0808_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2000, meaning clk cycles per ADC clock period (100 MHz / 2000 = 50 kHz); legal range is even values >= 4.
REQ-002 SHALL have parameter AVG_LOG2, default 0, meaning log2 of conversions averaged per channel; legal range 0..3.
REQ-003 SHALL have parameter EOC_TIMEOUT, default 255, meaning the maximum number of adc_tick periods spent waiting on each EOC edge.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock (CLK100MHZ).
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: scanning runs while high.
REQ-007 SHALL have port ch_mask, input, 8 bits: channels included in the scan.
REQ-008 SHALL have port adc_data, input, 8 bits: ADC0808 data bus.
REQ-009 SHALL have port adc_eoc, input, 1 bit: ADC0808 end-of-conversion, asynchronous.
REQ-010 SHALL have port adc_clk, output, 1 bit: ADC0808 clock, 50% duty.
REQ-011 SHALL have ports adc_ale, adc_start, adc_oe, outputs, 1 bit each: ADC0808 controls.
REQ-012 SHALL have port adc_addr, output, 3 bits: analog channel select.
REQ-013 SHALL have port sample_data, output, 8 bits: averaged result.
REQ-014 SHALL have port sample_ch, output, 3 bits: channel of sample_data.
REQ-015 SHALL have port sample_valid, output, 1 bit: one-clk strobe for a new sample.
REQ-016 SHALL have port timeout_err, output, 1 bit: sticky EOC-timeout flag.

Function
REQ-017 SHALL divide clk by CLK_DIV into adc_clk and generate adc_tick, a one-clk pulse on each adc_clk rising edge; all FSM transitions except CAPTURE SHALL occur on adc_tick.
REQ-018 SHALL pass adc_eoc through a 2-flop synchronizer before use.
REQ-019 FSM states SHALL be IDLE, SELECT, LATCH, START, WAIT_LO, WAIT_HI, READ, CAPTURE.
REQ-020 IDLE -> SELECT when enable=1 and ch_mask!=0; the scan pointer SHALL then move to the next set mask bit, searching ascending from the previous channel and wrapping 7->0.
REQ-021 SELECT SHALL drive adc_addr for one tick; LATCH SHALL assert adc_ale for one tick; START SHALL assert adc_start for one tick (adc_ale deasserted).
REQ-022 WAIT_LO SHALL wait for synchronized EOC=0, then WAIT_HI SHALL wait for EOC=1; exceeding EOC_TIMEOUT ticks in either state SHALL set timeout_err, discard the accumulator, and go to IDLE.
REQ-023 READ SHALL assert adc_oe for one tick; CAPTURE SHALL latch adc_data into the accumulator on the next clk, with adc_oe still high.
REQ-024 The accumulator SHALL be 8+AVG_LOG2 bits wide and SHALL sum 2^AVG_LOG2 conversions of the same channel, re-entering LATCH without reselecting between conversions.
REQ-025 After the last conversion, sample_data SHALL be set to the accumulator >> AVG_LOG2 (truncated), sample_ch to the channel, and sample_valid pulsed for exactly one clk; the FSM then goes to IDLE.
REQ-026 ch_mask SHALL be sampled only at the IDLE->SELECT transition; changes mid-channel do not affect the current channel.
REQ-027 Deasserting enable mid-channel SHALL let the current channel complete and emit its sample, then hold IDLE.
REQ-028 timeout_err SHALL be cleared only by reset.
REQ-029 When mask has one bit set, SHALL repeatedly convert that channel.

Reset
REQ-030 On reset_n=0: FSM in IDLE; adc_clk, adc_ale, adc_start, adc_oe, and sample_valid at 0; adc_addr, sample_data, sample_ch, accumulator, and divider at 0; timeout_err at 0; scan pointer at 7, so the first scan selects the lowest set bit.
REQ-031 Reset asserted mid-conversion SHALL immediately force all outputs to reset values; no sample is emitted.

Structure
REQ-032 The shared package adc_pkg SHALL hold the FSM state enum, the ADC0808 channel-count constant (8), and the default CLK_DIV.
REQ-033 The clock divider plus adc_tick SHALL be a sub-module, adc_clk_div; the synchronizer SHALL be inline.

Verification
REQ-034 Test: CLK_DIV=4, AVG_LOG2=0, mask=8'h05, model returns 8'hA0 on ch0 and 8'h3C on ch2 -> samples alternate (0,A0),(2,3C),(0,A0).
REQ-035 Test: AVG_LOG2=2, ch3 returns 10,11,12,13 -> single sample_data=11 (46>>2), sample_ch=3.
REQ-036 Test: EOC held high forever, EOC_TIMEOUT=8 -> timeout_err=1 after 8 ticks in WAIT_LO, no sample_valid, next channel attempted.
REQ-037 Test: enable dropped during WAIT_HI -> that sample is emitted, then FSM stays IDLE, adc_start never reasserts.
REQ-038 Test: reset_n pulsed low during READ -> adc_oe=0 and sample_valid=0 asynchronously; the first scan after release selects the lowest set bit.
REQ-039 Test: mask=8'h00 with enable=1 -> no ale/start activity for 1000 ticks.
